fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Sits directly upstream of the ID-stage hazard detection unit. It drives the IF/ID pipeline register that the hazard unit inspects, and it consumes that unit's stall output and the ID-stage branch/jump redirect.
- Decouples the blocking I-cache from ID stalls with a small prefetch queue, so fetch continues while ID is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FQ_DEPTH, 2, prefetch queue entries (power of 2, ≥2).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- stall_i  in  1  hazard-unit stall; holds IF/ID contents.
- flush_i  in  1  taken branch/jump/jr resolved in ID; redirect fetch.
- redirect_pc  in  32  target PC, valid when flush_i=1; bits [1:0] ignored.
- ic_req  out  1  I-cache read request.
- ic_addr  out  30  word address (pc[31:2]).
- ic_rdata  in  32  instruction, valid when ic_ready=1.
- ic_ready  in  1  request completes this cycle.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  instruction to ID (32'h0 NOP when invalid).
- if_id_pc_plus4  out  32  PC+4 of that instruction.
- fetch_empty  out  1  queue empty and IF/ID invalid; debug and perf only.

Behaviour:
- Reset (async, rst_n=0) values:
  - fetch_pc=RESET_PC.
  - FSM=IDLE, queue empty.
  - ic_req=0, ic_addr=RESET_PC[31:2].
  - if_id_valid=0, if_id_instr=0, if_id_pc_plus4=0, fetch_empty=1.
- Cache handshake:
  - Blocking cache, one request outstanding at most.
  - Once raised, ic_req and ic_addr stay stable until the cycle with ic_ready=1.
  - ic_ready may arrive in the same cycle as the request (hit).
- FSM states:
  - IDLE: ic_req=0.
    - Go to REQ when occupancy < FQ_DEPTH and flush_i=0.
  - REQ: ic_req=1, ic_addr=fetch_pc[31:2].
    - On ic_ready with no flush: push {ic_rdata, fetch_pc+4}; fetch_pc += 4.
    - Stay in REQ if the queue still has room after the push and any same-cycle pop; otherwise go to IDLE.
    - flush_i with no ic_ready: fetch_pc <= redirect_pc; go to DISCARD.
    - flush_i with ic_ready: drop the data; fetch_pc <= redirect_pc; go to IDLE.
  - DISCARD: ic_req=1, old address held.
    - On ic_ready: drop the data; go to IDLE.
    - A further flush_i overwrites fetch_pc only.
- Occupancy counts queued entries only. The in-flight request is reserved: a new request issues only if count + same-cycle push − same-cycle pop < FQ_DEPTH, so a push never overflows.
- IF/ID update:
  - flush_i=1 (priority over stall_i): IF/ID <= bubble (valid=0, instr=0, pc_plus4=0); queue cleared in the same edge.
  - Else stall_i=1: IF/ID and queue head held; pushes still accepted.
  - Else queue non-empty: pop head into IF/ID, valid=1.
  - Else: IF/ID <= bubble.
- Latency:
  - ic_ready at cycle N → queue entry at edge N → IF/ID valid after edge N+1, if not stalled.
  - No bypass from ic_rdata to IF/ID.
  - After rst_n rises: ic_req=1 in the first cycle, at RESET_PC.
- Simultaneous events:
  - Push and pop in the same cycle leave count unchanged.
  - Push into a full queue cannot occur (reservation rule).
  - Flush in the same cycle as push or pop: the flush wins; queue empty afterwards.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Reset asserted mid-request: state is cleared immediately. The cache controller is reset by the same rst_n, so no stale ic_ready is expected.

Decomposition:
- fetch_pkg holds:
  - NOP_INSTR=32'h0.
  - FSM state encoding: IDLE, REQ, DISCARD.
  - Queue entry struct {instr[31:0], pc_plus4[31:0]}.
  - RESET_PC default.
- One sub-module, fetch_queue: synchronous FIFO, FQ_DEPTH×64 bits, with push, pop and clear, and count/full/empty outputs. Clear has priority over push and pop.

Test Plan:
- Reset with ic_ready tied 1 → ic_addr=0,1,2… each cycle; if_id_instr follows the memory image from the 3rd cycle; if_id_pc_plus4=4,8,12.
- stall_i=1 for 4 cycles with ic_ready=1 → queue fills to 2 entries, ic_req drops. After release, IF/ID shows the sequential instructions with no loss or duplicate.
- Miss: ic_ready delayed 10 cycles → ic_addr held stable throughout; IF/ID bubbles (valid=0) until data arrives.
- flush_i with redirect_pc=32'h40 while a miss is outstanding at 0x8 → data for 0x8 dropped; next ic_addr=0x10; first valid instruction has pc_plus4=0x44.
- flush_i and stall_i in the same cycle with a full queue → IF/ID becomes a bubble, queue empty, next fetch at redirect_pc.
- rst_n pulsed low mid-request → outputs return to reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// No logic; types only.
// Imported by fetch_queue and fetch_stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO between the I-cache and the IF/ID register.
// Latency: a pushed entry is visible at head_o one cycle after the push edge.
// Backpressure: push is ignored when full unless popped in the same cycle; clear beats push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  fq_entry_t                push_dat_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output fq_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping; clear empties the queue in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Entry storage; contents are only observed while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: blocking I-cache fetch into a prefetch queue feeding the IF/ID register.
// Latency: ic_ready at cycle N -> queued at edge N -> IF/ID valid after edge N+1 (no bypass).
// Backpressure: stall_i holds IF/ID while fetch keeps filling the queue; a request issues only if its slot is reserved.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc,
    output logic        ic_req,
    output logic [29:0] ic_addr,
    input  logic [31:0] ic_rdata,
    input  logic        ic_ready,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        fetch_empty
);

    localparam int CW = $clog2(FQ_DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [29:0]   req_addr_q, req_addr_d;
    logic          if_id_valid_q;
    logic [31:0]   if_id_instr_q;
    logic [31:0]   if_id_pc_plus4_q;

    logic          fq_push, fq_pop, fq_full, fq_empty;
    fq_entry_t     fq_wdat, fq_head;
    logic [CW:0]   fq_count;
    logic [CW+1:0] occ_after;
    logic          room;
    logic [31:0]   redirect_aligned;

    assign redirect_aligned = redirect_pc & PC_ALIGN_MASK;

    // Flush wins over everything; stall freezes the head; otherwise drain one entry per cycle.
    assign fq_pop  = !flush_i && !stall_i && !fq_empty;
    assign fq_push = (state_q == ST_REQ) && ic_ready && !flush_i;
    assign fq_wdat = '{instr: ic_rdata, pc_plus4: fetch_pc_q + 32'd4};

    // Occupancy after this edge; the next request may only issue if its slot is still free.
    assign occ_after = (CW+2)'(fq_count) + (CW+2)'(fq_push) - (CW+2)'(fq_pop);
    assign room      = occ_after < (CW+2)'(FQ_DEPTH);

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fq_push),
        .push_dat_i (fq_wdat),
        .pop_i      (fq_pop),
        .clear_i    (flush_i),
        .head_o     (fq_head),
        .count_o    (fq_count),
        .full_o     (fq_full),
        .empty_o    (fq_empty)
    );

    // Fetch FSM and PC state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC[31:2];
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Next-state, PC update and cache request outputs.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        ic_req     = 1'b0;
        ic_addr    = fetch_pc_q[31:2];
        case (state_q)
            ST_IDLE: begin
                if (flush_i)   fetch_pc_d = redirect_aligned;
                else if (room) state_d    = ST_REQ;
            end
            ST_REQ: begin
                ic_req = 1'b1;
                if (flush_i) begin
                    fetch_pc_d = redirect_aligned;
                    if (ic_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Remember the abandoned address: the cache still needs it stable.
                        req_addr_d = fetch_pc_q[31:2];
                        state_d    = ST_DISCARD;
                    end
                end else if (ic_ready) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (!room) state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                ic_req  = 1'b1;
                ic_addr = req_addr_q;
                if (flush_i)  fetch_pc_d = redirect_aligned;
                if (ic_ready) state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // IF/ID register: flush bubbles, stall holds, otherwise load queue head or bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid_q    <= 1'b0;
            if_id_instr_q    <= NOP_INSTR;
            if_id_pc_plus4_q <= 32'h0;
        end else if (flush_i) begin
            if_id_valid_q    <= 1'b0;
            if_id_instr_q    <= NOP_INSTR;
            if_id_pc_plus4_q <= 32'h0;
        end else if (!stall_i) begin
            if (!fq_empty) begin
                if_id_valid_q    <= 1'b1;
                if_id_instr_q    <= fq_head.instr;
                if_id_pc_plus4_q <= fq_head.pc_plus4;
            end else begin
                if_id_valid_q    <= 1'b0;
                if_id_instr_q    <= NOP_INSTR;
                if_id_pc_plus4_q <= 32'h0;
            end
        end
    end

    assign if_id_valid    = if_id_valid_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign fetch_empty    = fq_empty && !if_id_valid_q;

    // The reservation rule must make a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fq_push && fq_full && !fq_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational I-cache image model.
// Inputs driven and outputs checked on the falling clock edge.
// ic_ready controlled per-vector to model hits, misses and discards.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i;
    logic [31:0] redirect_pc;
    logic        ic_req;
    logic [29:0] ic_addr;
    logic [31:0] ic_rdata;
    logic        ic_ready;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        fetch_empty;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] img(input logic [29:0] a);
        return {2'b11, a};
    endfunction

    assign ic_rdata = img(ic_addr);

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .redirect_pc    (redirect_pc),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_rdata       (ic_rdata),
        .ic_ready       (ic_ready),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .fetch_empty    (fetch_empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p4);
        check({tag, ".valid"}, 32'(if_id_valid), 32'(v));
        check({tag, ".instr"}, if_id_instr, ins);
        check({tag, ".pc4"},   if_id_pc_plus4, p4);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [29:0] a);
        check({tag, ".req"},  32'(ic_req), 32'(r));
        check({tag, ".addr"}, 32'(ic_addr), 32'(a));
    endtask

    task automatic chk_reset(input string tag);
        chk_req(tag, 1'b0, 30'h0);
        chk_ifid(tag, 1'b0, 32'h0, 32'h0);
        check({tag, ".empty"}, 32'(fetch_empty), 32'h1);
    endtask

    initial begin
        rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_pc = 32'h0; ic_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) tick();
        chk_reset("rst");

        // Streaming hits straight out of reset.
        rst_n = 1'b1;
        tick(); chk_req("s0", 1'b1, 30'd0); check("s0.valid", 32'(if_id_valid), 32'h0);
        tick(); chk_req("s1", 1'b1, 30'd1); check("s1.valid", 32'(if_id_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_req("s2", 1'b1, 30'(i + 2));
            chk_ifid("s2", 1'b1, img(30'(i)), 32'(4 * (i + 1)));
        end

        // Stall four cycles: queue fills, fetch pauses, nothing lost on release.
        stall_i = 1'b1;
        tick(); chk_req("st0", 1'b0, 30'd5); chk_ifid("st0", 1'b1, img(30'd2), 32'd12);
        repeat (3) tick();
        chk_req("st3", 1'b0, 30'd5); chk_ifid("st3", 1'b1, img(30'd2), 32'd12);
        check("st3.empty", 32'(fetch_empty), 32'h0);
        stall_i = 1'b0;
        tick(); chk_ifid("rel0", 1'b1, img(30'd3), 32'd16); chk_req("rel0", 1'b1, 30'd5);
        tick(); chk_ifid("rel1", 1'b1, img(30'd4), 32'd20); chk_req("rel1", 1'b1, 30'd6);

        // Ten-cycle miss at word 6.
        ic_ready = 1'b0;
        tick(); chk_ifid("m0", 1'b1, img(30'd5), 32'd24); chk_req("m0", 1'b1, 30'd6);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_req("miss", 1'b1, 30'd6);
            check("miss.valid", 32'(if_id_valid), 32'h0);
            check("miss.empty", 32'(fetch_empty), 32'h1);
        end
        ic_ready = 1'b1;
        tick(); check("mr0.valid", 32'(if_id_valid), 32'h0); chk_req("mr0", 1'b1, 30'd7);
        tick(); chk_ifid("mr1", 1'b1, img(30'd6), 32'd28);

        // Flush to 0x40 while the miss at 0x8 is outstanding.
        rst_n = 1'b0; tick(); chk_reset("rst2"); rst_n = 1'b1;
        tick(); tick(); tick();
        ic_ready = 1'b0;
        chk_ifid("f0", 1'b1, img(30'd0), 32'd4); chk_req("f0", 1'b1, 30'd2);
        tick(); chk_ifid("f1", 1'b1, img(30'd1), 32'd8); chk_req("f1", 1'b1, 30'd2);
        flush_i = 1'b1; redirect_pc = 32'h0000_0040;
        tick(); chk_req("fd", 1'b1, 30'd2); check("fd.valid", 32'(if_id_valid), 32'h0);
        flush_i = 1'b0; ic_ready = 1'b1;
        tick(); chk_req("fi", 1'b0, 30'h10); check("fi.valid", 32'(if_id_valid), 32'h0);
        tick(); chk_req("fr", 1'b1, 30'h10);
        tick(); check("fq.valid", 32'(if_id_valid), 32'h0); chk_req("fq", 1'b1, 30'h11);
        tick(); chk_ifid("fv", 1'b1, img(30'h10), 32'h44);

        // Flush and stall together with a full queue.
        stall_i = 1'b1;
        tick(); chk_req("fs0", 1'b0, 30'h13); chk_ifid("fs0", 1'b1, img(30'h10), 32'h44);
        flush_i = 1'b1; redirect_pc = 32'h0000_0100;
        tick(); chk_ifid("fs1", 1'b0, 32'h0, 32'h0); chk_req("fs1", 1'b0, 30'h40);
        check("fs1.empty", 32'(fetch_empty), 32'h1);
        flush_i = 1'b0; stall_i = 1'b0;
        tick(); chk_req("fs2", 1'b1, 30'h40); check("fs2.valid", 32'(if_id_valid), 32'h0);
        tick(); check("fs3.valid", 32'(if_id_valid), 32'h0);
        tick(); chk_ifid("fs4", 1'b1, img(30'h40), 32'h104);

        // Asynchronous reset in the middle of a pending miss.
        ic_ready = 1'b0;
        tick(); chk_ifid("ar0", 1'b1, img(30'h41), 32'h108); chk_req("ar0", 1'b1, 30'h42);
        #2 rst_n = 1'b0;
        #1 chk_reset("arst");
        @(negedge clk);
        rst_n = 1'b1; ic_ready = 1'b1;
        tick(); chk_req("ar1", 1'b1, 30'd0);
        tick(); chk_req("ar2", 1'b1, 30'd1);
        tick(); chk_ifid("ar3", 1'b1, img(30'd0), 32'd4); chk_req("ar3", 1'b1, 30'd2);

        // Flush with simultaneous ready to a misaligned top-of-memory target; PC wraps to 0.
        flush_i = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick(); chk_req("w0", 1'b0, 30'h3FFF_FFFF); check("w0.valid", 32'(if_id_valid), 32'h0);
        flush_i = 1'b0;
        tick(); chk_req("w1", 1'b1, 30'h3FFF_FFFF);
        tick(); chk_req("w2", 1'b1, 30'h0); check("w2.valid", 32'(if_id_valid), 32'h0);
        tick(); chk_ifid("w3", 1'b1, img(30'h3FFF_FFFF), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
